// File: rtl/alu_cmd_driver.sv
// Command/response sequencer for an external combinational 16-bit ALU: issues operands,
// holds them SETTLE cycles, captures the result. Optional accumulator: define ALU_DRV_ACC_EN.
module alu_cmd_driver #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opc,
    input  logic [15:0] cmd_m,
    input  logic [15:0] cmd_n,
    input  logic        cmd_c,
    input  logic        cmd_use_acc,
    output logic [2:0]  alu_opc,
    output logic [15:0] alu_m,
    output logic [15:0] alu_n,
    output logic        alu_c,
    input  logic [15:0] alu_f,
    input  logic        alu_neg,
    input  logic        alu_zer,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_neg,
    output logic        rsp_zer,
    output logic        busy,
    output logic [7:0]  op_cnt
);

    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("alu_cmd_driver: SETTLE must be 1..15");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] m_sel;

`ifdef ALU_DRV_ACC_EN
    logic [15:0] acc;
    assign m_sel = cmd_use_acc ? acc : cmd_m;
`else
    logic unused_use_acc;
    assign unused_use_acc = cmd_use_acc;
    assign m_sel = cmd_m;
`endif

    // Handshake/status outputs are registered next to the state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            alu_opc   <= '0;
            alu_m     <= '0;
            alu_n     <= '0;
            alu_c     <= 1'b0;
            rsp_data  <= '0;
            rsp_neg   <= 1'b0;
            rsp_zer   <= 1'b0;
            op_cnt    <= '0;
`ifdef ALU_DRV_ACC_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_opc   <= cmd_opc;
                        alu_m     <= m_sel;
                        alu_n     <= cmd_n;
                        alu_c     <= cmd_c;
                        cnt       <= SETTLE_LD;
                        state     <= EXEC;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        rsp_data  <= alu_f;
                        rsp_neg   <= alu_neg;
                        rsp_zer   <= alu_zer;
`ifdef ALU_DRV_ACC_EN
                        acc       <= alu_f;
`endif
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_cnt    <= op_cnt + 8'd1;
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
